// File: rtl/pio_req_router_pkg.sv
// Shared definitions for the PIO request router: stream widths, tuser field
// offsets, FSM state encoding and the latched head record.
`ifndef PIO_REQ_ROUTER_DEFS
`define PIO_REQ_ROUTER_DEFS
`define PIO_DATA_W 64
`define PIO_USER_W 140
`define PIO_HEAD_W 132
`endif

package pio_req_router_pkg;

  localparam int USER_IS_WR   = 139;
  localparam int USER_BAR_HI  = 138;
  localparam int USER_BAR_LO  = 136;
  localparam int USER_ADDR_HI = 127;
  localparam int USER_ADDR_LO = 96;
  localparam int CC_HEAD_W    = 96;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FWD  = 2'd1,
    ST_DROP = 2'd2
  } state_e;

  // Packed so that the struct image is exactly the m_axis head bus.
  typedef struct packed {
    logic                 is_wr;
    logic [2:0]           bar_id;
    logic [31:0]          addr;
    logic [CC_HEAD_W-1:0] cc_head;
  } head_t;

  function automatic head_t user_to_head(input logic [`PIO_USER_W-1:0] user);
    head_t h;
    h.is_wr   = user[USER_IS_WR];
    h.bar_id  = user[USER_BAR_HI:USER_BAR_LO];
    h.addr    = user[USER_ADDR_HI:USER_ADDR_LO];
    h.cc_head = user[CC_HEAD_W-1:0];
    return h;
  endfunction

endpackage

// File: rtl/pio_req_router_if.sv
// Request stream bundle: one upstream AXI-S style port and CHANNEL_NUM
// downstream request channels.
interface pio_req_router_if #(
  parameter int CHANNEL_NUM = 8,
  parameter int DATA_W      = `PIO_DATA_W
);

  logic [DATA_W-1:0]                         s_axis_req_tdata;
  logic [`PIO_USER_W-1:0]                    s_axis_req_tuser;
  logic                                      s_axis_req_tlast;
  logic                                      s_axis_req_tvalid;
  logic                                      s_axis_req_tready;

  logic [CHANNEL_NUM-1:0][DATA_W-1:0]        m_axis_req_data;
  logic [CHANNEL_NUM-1:0][`PIO_HEAD_W-1:0]   m_axis_req_head;
  logic [CHANNEL_NUM-1:0]                    m_axis_req_last;
  logic [CHANNEL_NUM-1:0]                    m_axis_req_valid;
  logic [CHANNEL_NUM-1:0]                    m_axis_req_ready;

  // Router side.
  modport slave (
    input  s_axis_req_tdata, s_axis_req_tuser, s_axis_req_tlast, s_axis_req_tvalid,
    output s_axis_req_tready,
    output m_axis_req_data, m_axis_req_head, m_axis_req_last, m_axis_req_valid,
    input  m_axis_req_ready
  );

  // Requester / consumer side.
  modport master (
    output s_axis_req_tdata, s_axis_req_tuser, s_axis_req_tlast, s_axis_req_tvalid,
    input  s_axis_req_tready,
    input  m_axis_req_data, m_axis_req_head, m_axis_req_last, m_axis_req_valid,
    output m_axis_req_ready
  );

endinterface

// File: rtl/pio_req_router_win_match.sv
// Combinational address-window decoder: compares one head against the whole
// window table and reports the lowest-index hit.
module pio_win_match #(
  parameter int CHANNEL_NUM = 8,
  parameter int ADDR_W      = 32,
  parameter int CHNL_W      = $clog2(CHANNEL_NUM)
) (
  input  logic [CHANNEL_NUM-1:0]             win_en,
  input  logic [CHANNEL_NUM-1:0][ADDR_W-1:0] win_base,
  input  logic [CHANNEL_NUM-1:0][ADDR_W-1:0] win_len,
  input  logic [CHANNEL_NUM-1:0][7:0]        win_mask,
  input  logic [2:0]                         bar_id,
  input  logic [ADDR_W-1:0]                  addr,
  output logic                               hit,
  output logic [CHNL_W-1:0]                  idx
);

  logic [CHANNEL_NUM-1:0] hit_vec;

  // The upper bound is formed one bit wider so a window at the top of the
  // address space cannot wrap around to low addresses; len = 0 is empty.
  always_comb begin
    for (int i = 0; i < CHANNEL_NUM; i++) begin
      hit_vec[i] = win_en[i] && win_mask[i][bar_id] &&
                   ({1'b0, addr} >= {1'b0, win_base[i]}) &&
                   ({1'b0, addr} <  ({1'b0, win_base[i]} + {1'b0, win_len[i]}));
    end
  end

  // Scanning downward lets the lowest matching index be the last one written.
  always_comb begin
    hit = 1'b0;
    idx = '0;
    for (int i = CHANNEL_NUM - 1; i >= 0; i--) begin
      if (hit_vec[i]) begin
        hit = 1'b1;
        idx = CHNL_W'(i);
      end
    end
  end

endmodule

// File: rtl/pio_req_router.sv
// PIO request router: steers each upstream packet to one of CHANNEL_NUM
// downstream channels by address window, through a one-deep output slice.
module pio_req_router
  import pio_req_router_pkg::*;
#(
  parameter int CHANNEL_NUM = 8,
  parameter int DATA_W      = `PIO_DATA_W,
  parameter int ADDR_W      = 32,
  parameter int DEF_CHNL    = 0,
  parameter int DROP_MISS   = 0,
  localparam int CHNL_W     = $clog2(CHANNEL_NUM)
) (
  input  logic                clk,
  input  logic                rst_n,
  pio_req_router_if.slave     req,
  input  logic                cfg_wr_en,
  input  logic [CHNL_W-1:0]   cfg_idx,
  input  logic [ADDR_W-1:0]   cfg_base,
  input  logic [ADDR_W-1:0]   cfg_len,
  input  logic [7:0]          cfg_bar_mask,
  input  logic                cfg_en,
  output logic [15:0]         miss_cnt,
  output logic                drop_pulse
);

  // Window table
  logic [CHANNEL_NUM-1:0]             win_en;
  logic [CHANNEL_NUM-1:0][ADDR_W-1:0] win_base;
  logic [CHANNEL_NUM-1:0][ADDR_W-1:0] win_len;
  logic [CHANNEL_NUM-1:0][7:0]        win_mask;

  // NOTE: the window table is a handful of flops, not a RAM, so it is reset
  // like any other state; this also guarantees every window starts disabled.
  // NOTE: sequential state is always updated with non-blocking assignments.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_en   <= '0;
      win_base <= '0;
      win_len  <= '0;
      win_mask <= '0;
    end else if (cfg_wr_en && (int'(cfg_idx) < CHANNEL_NUM)) begin
      win_en[cfg_idx]   <= cfg_en;
      win_base[cfg_idx] <= cfg_base;
      win_len[cfg_idx]  <= cfg_len;
      win_mask[cfg_idx] <= cfg_bar_mask;
    end
  end

  // Incoming head decode
  head_t             in_head;
  logic [ADDR_W-1:0] in_addr;
  logic              unused_user_bits;

  assign in_head          = user_to_head(req.s_axis_req_tuser);
  assign in_addr          = ADDR_W'(in_head.addr);
  assign unused_user_bits = ^req.s_axis_req_tuser[USER_BAR_LO-1:USER_ADDR_HI+1];

  logic              match_hit;
  logic [CHNL_W-1:0] match_idx;

  pio_win_match #(
    .CHANNEL_NUM (CHANNEL_NUM),
    .ADDR_W      (ADDR_W),
    .CHNL_W      (CHNL_W)
  ) u_win_match (
    .win_en   (win_en),
    .win_base (win_base),
    .win_len  (win_len),
    .win_mask (win_mask),
    .bar_id   (in_head.bar_id),
    .addr     (in_addr),
    .hit      (match_hit),
    .idx      (match_idx)
  );

  // Output slice and upstream handshake
  logic              out_valid_q;
  logic [CHNL_W-1:0] out_chnl_q;
  logic [DATA_W-1:0] out_data_q;
  head_t             out_head_q;
  logic              out_last_q;
  logic              take_in;
  logic              accept;

  // The slice can take a beat when empty or when its current beat leaves.
  assign take_in               = !out_valid_q || req.m_axis_req_ready[out_chnl_q];
  assign req.s_axis_req_tready = rst_n && take_in;
  assign accept                = req.s_axis_req_tvalid && req.s_axis_req_tready;

  // Packet FSM
  state_e            state_q, state_d;
  logic [CHNL_W-1:0] lock_chnl_q, lock_chnl_d;
  head_t             head_q, head_d;
  logic [CHNL_W-1:0] beat_chnl;
  head_t             beat_head;
  logic              beat_drop;
  logic              first_miss;

  // NOTE: every output of this block gets a default first, so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    state_d     = state_q;
    lock_chnl_d = lock_chnl_q;
    head_d      = head_q;
    beat_chnl   = lock_chnl_q;
    beat_head   = head_q;
    beat_drop   = (state_q == ST_DROP);
    first_miss  = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        // Routing uses the registered table, so a same-cycle cfg write lands later.
        beat_head  = in_head;
        first_miss = !match_hit;
        beat_chnl  = match_hit ? match_idx : CHNL_W'(DEF_CHNL);
        beat_drop  = !match_hit && (DROP_MISS != 0);
        if (accept) begin
          lock_chnl_d = beat_chnl;
          head_d      = in_head;
          if (!req.s_axis_req_tlast) state_d = beat_drop ? ST_DROP : ST_FWD;
        end
      end
      ST_FWD, ST_DROP: begin
        if (accept && req.s_axis_req_tlast) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      lock_chnl_q <= '0;
      head_q      <= '0;
    end else begin
      state_q     <= state_d;
      lock_chnl_q <= lock_chnl_d;
      head_q      <= head_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_chnl_q  <= '0;
      out_data_q  <= '0;
      out_head_q  <= '0;
      out_last_q  <= 1'b0;
    end else if (take_in) begin
      out_valid_q <= accept && !beat_drop;
      if (accept && !beat_drop) begin
        out_chnl_q <= beat_chnl;
        out_data_q <= req.s_axis_req_tdata;
        out_head_q <= beat_head;
        out_last_q <= req.s_axis_req_tlast;
      end
    end
  end

  // Data/head/last are broadcast; only the selected channel sees valid.
  always_comb begin
    for (int i = 0; i < CHANNEL_NUM; i++) begin
      req.m_axis_req_valid[i] = out_valid_q && (out_chnl_q == CHNL_W'(i));
      req.m_axis_req_data[i]  = out_data_q;
      req.m_axis_req_head[i]  = out_head_q;
      req.m_axis_req_last[i]  = out_last_q;
    end
  end

  // Statistics: drop_pulse lines up with the cycle the beat would have shown downstream.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      miss_cnt   <= '0;
      drop_pulse <= 1'b0;
    end else begin
      if (accept && first_miss && (miss_cnt != 16'hFFFF)) miss_cnt <= miss_cnt + 16'd1;
      drop_pulse <= accept && beat_drop && req.s_axis_req_tlast;
    end
  end

endmodule

// File: tb/tb_pio_req_router.sv
// Directed bench for pio_req_router: one instance with DROP_MISS=0 and one
// with DROP_MISS=1, sharing clock, reset and the configuration port.
module tb_pio_req_router;
  import pio_req_router_pkg::*;

  localparam int CN = 8;
  localparam int DW = 64;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cfg_wr_en = 1'b0;
  logic [2:0]  cfg_idx = '0;
  logic [31:0] cfg_base = '0;
  logic [31:0] cfg_len = '0;
  logic [7:0]  cfg_bar_mask = '0;
  logic        cfg_en = 1'b0;
  logic [15:0] miss_cnt0, miss_cnt1;
  logic        drop_pulse0, drop_pulse1;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  pio_req_router_if #(.CHANNEL_NUM(CN), .DATA_W(DW)) if0 ();
  pio_req_router_if #(.CHANNEL_NUM(CN), .DATA_W(DW)) if1 ();

  pio_req_router #(.CHANNEL_NUM(CN), .DATA_W(DW), .ADDR_W(32), .DEF_CHNL(0), .DROP_MISS(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .req(if0),
    .cfg_wr_en(cfg_wr_en), .cfg_idx(cfg_idx), .cfg_base(cfg_base), .cfg_len(cfg_len),
    .cfg_bar_mask(cfg_bar_mask), .cfg_en(cfg_en),
    .miss_cnt(miss_cnt0), .drop_pulse(drop_pulse0)
  );

  pio_req_router #(.CHANNEL_NUM(CN), .DATA_W(DW), .ADDR_W(32), .DEF_CHNL(0), .DROP_MISS(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .req(if1),
    .cfg_wr_en(cfg_wr_en), .cfg_idx(cfg_idx), .cfg_base(cfg_base), .cfg_len(cfg_len),
    .cfg_bar_mask(cfg_bar_mask), .cfg_en(cfg_en),
    .miss_cnt(miss_cnt1), .drop_pulse(drop_pulse1)
  );

  task automatic check(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [`PIO_USER_W-1:0] mk_user(input logic wr, input logic [2:0] bar,
                                                     input logic [31:0] addr, input logic [95:0] cc);
    logic [`PIO_USER_W-1:0] u;
    u = '0;
    u[139]     = wr;
    u[138:136] = bar;
    u[127:96]  = addr;
    u[95:0]    = cc;
    return u;
  endfunction

  task automatic wr_win(input logic [2:0] idx, input logic [31:0] base, input logic [31:0] len,
                        input logic [7:0] mask, input logic en);
    cfg_idx = idx; cfg_base = base; cfg_len = len; cfg_bar_mask = mask; cfg_en = en;
    cfg_wr_en = 1'b1;
    step();
    cfg_wr_en = 1'b0;
  endtask

  task automatic send0(input logic [63:0] data, input logic [`PIO_USER_W-1:0] user, input logic last);
    if0.s_axis_req_tdata  = data;
    if0.s_axis_req_tuser  = user;
    if0.s_axis_req_tlast  = last;
    if0.s_axis_req_tvalid = 1'b1;
    step();
    if0.s_axis_req_tvalid = 1'b0;
  endtask

  task automatic send1(input logic [63:0] data, input logic [`PIO_USER_W-1:0] user, input logic last);
    if1.s_axis_req_tdata  = data;
    if1.s_axis_req_tuser  = user;
    if1.s_axis_req_tlast  = last;
    if1.s_axis_req_tvalid = 1'b1;
    step();
    if1.s_axis_req_tvalid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    if0.s_axis_req_tdata = '0; if0.s_axis_req_tuser = '0; if0.s_axis_req_tlast = 1'b0;
    if0.s_axis_req_tvalid = 1'b0; if0.m_axis_req_ready = '1;
    if1.s_axis_req_tdata = '0; if1.s_axis_req_tuser = '0; if1.s_axis_req_tlast = 1'b0;
    if1.s_axis_req_tvalid = 1'b0; if1.m_axis_req_ready = '1;

    // Reset state
    #12;
    check("rst_tready", if0.s_axis_req_tready, 0);
    check("rst_valid", if0.m_axis_req_valid, 0);
    check("rst_miss", miss_cnt0, 0);
    check("rst_drop", drop_pulse1, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("idle_tready", if0.s_axis_req_tready, 1);

    // Single-beat write into window 2
    wr_win(3'd2, 32'h1000, 32'h100, 8'h01, 1'b1);
    send0(64'h11, mk_user(1'b1, 3'd0, 32'h10F0, 96'hC0FFEE), 1'b1);
    check("w2_valid", if0.m_axis_req_valid, 8'h04);
    check("w2_addr", if0.m_axis_req_head[2][127:96], 32'h10F0);
    check("w2_iswr", if0.m_axis_req_head[2][131], 1);
    check("w2_cc", if0.m_axis_req_head[2][95:0], 96'hC0FFEE);
    check("w2_data", if0.m_axis_req_data[2], 64'h11);
    check("w2_last", if0.m_axis_req_last[2], 1);
    step();
    check("w2_drain", if0.m_axis_req_valid, 0);

    // 4-beat packet, window 2 moved during beat 2; later tuser beats carry junk
    send0(64'hA1, mk_user(1'b0, 3'd0, 32'h1010, 96'h1), 1'b0);
    check("pkt_b1_valid", if0.m_axis_req_valid, 8'h04);
    check("pkt_b1_data", if0.m_axis_req_data[2], 64'hA1);
    cfg_idx = 3'd2; cfg_base = 32'h8000; cfg_len = 32'h100; cfg_bar_mask = 8'h01; cfg_en = 1'b1;
    cfg_wr_en = 1'b1;
    send0(64'hA2, mk_user(1'b1, 3'd5, 32'h5555, 96'h2), 1'b0);
    cfg_wr_en = 1'b0;
    check("pkt_b2_valid", if0.m_axis_req_valid, 8'h04);
    check("pkt_b2_data", if0.m_axis_req_data[2], 64'hA2);
    check("pkt_b2_addr", if0.m_axis_req_head[2][127:96], 32'h1010);
    send0(64'hA3, mk_user(1'b1, 3'd5, 32'h5555, 96'h3), 1'b0);
    check("pkt_b3_valid", if0.m_axis_req_valid, 8'h04);
    check("pkt_b3_cc", if0.m_axis_req_head[2][95:0], 96'h1);
    send0(64'hA4, mk_user(1'b1, 3'd5, 32'h5555, 96'h4), 1'b1);
    check("pkt_b4_valid", if0.m_axis_req_valid, 8'h04);
    check("pkt_b4_last", if0.m_axis_req_last[2], 1);
    check("pkt_b4_addr", if0.m_axis_req_head[2][127:96], 32'h1010);

    // Moved window now misses; miss goes to default channel 0
    send0(64'hB1, mk_user(1'b0, 3'd0, 32'h10F0, 96'h0), 1'b1);
    check("miss_valid", if0.m_axis_req_valid, 8'h01);
    check("miss_addr", if0.m_axis_req_head[0][127:96], 32'h10F0);
    check("miss_cnt1", miss_cnt0, 1);

    // cfg write coinciding with a first beat: old table routes it
    cfg_idx = 3'd2; cfg_base = 32'h1000; cfg_len = 32'h100; cfg_bar_mask = 8'h01; cfg_en = 1'b1;
    cfg_wr_en = 1'b1;
    send0(64'hB2, mk_user(1'b0, 3'd0, 32'h10F0, 96'h0), 1'b1);
    cfg_wr_en = 1'b0;
    check("samecyc_valid", if0.m_axis_req_valid, 8'h01);
    check("samecyc_miss", miss_cnt0, 2);
    send0(64'hB3, mk_user(1'b0, 3'd0, 32'h10F0, 96'h0), 1'b1);
    check("newtbl_valid", if0.m_axis_req_valid, 8'h04);
    send0(64'hB4, mk_user(1'b0, 3'd0, 32'h1100, 96'h0), 1'b1);
    check("upper_bound_valid", if0.m_axis_req_valid, 8'h01);
    check("upper_bound_miss", miss_cnt0, 3);

    // Overlapping windows 1 and 3, BAR mask, top-of-space window, empty window
    wr_win(3'd1, 32'h2000, 32'h1000, 8'h02, 1'b1);
    wr_win(3'd3, 32'h2800, 32'h100, 8'h02, 1'b1);
    send0(64'hC1, mk_user(1'b0, 3'd1, 32'h2810, 96'h0), 1'b1);
    check("overlap_valid", if0.m_axis_req_valid, 8'h02);
    send0(64'hC2, mk_user(1'b0, 3'd0, 32'h2810, 96'h0), 1'b1);
    check("barmask_valid", if0.m_axis_req_valid, 8'h01);
    check("barmask_miss", miss_cnt0, 4);
    wr_win(3'd5, 32'hFFFF_FF00, 32'h200, 8'hFF, 1'b1);
    send0(64'hD1, mk_user(1'b0, 3'd3, 32'hFFFF_FFF0, 96'h0), 1'b1);
    check("top_valid", if0.m_axis_req_valid, 8'h20);
    send0(64'hD2, mk_user(1'b0, 3'd3, 32'h0000_0010, 96'h0), 1'b1);
    check("nowrap_valid", if0.m_axis_req_valid, 8'h01);
    check("nowrap_miss", miss_cnt0, 5);
    wr_win(3'd6, 32'h3000, 32'h0, 8'hFF, 1'b1);
    send0(64'hE1, mk_user(1'b0, 3'd0, 32'h3000, 96'h0), 1'b1);
    check("len0_valid", if0.m_axis_req_valid, 8'h01);
    check("len0_miss", miss_cnt0, 6);

    // Channel 4 backpressure for 5 cycles mid-packet
    wr_win(3'd4, 32'h4000, 32'h100, 8'h01, 1'b1);
    send0(64'hF1, mk_user(1'b1, 3'd0, 32'h4000, 96'h0), 1'b0);
    check("stall_b1_valid", if0.m_axis_req_valid, 8'h10);
    if0.m_axis_req_ready[4] = 1'b0;
    if0.s_axis_req_tdata  = 64'hF2;
    if0.s_axis_req_tlast  = 1'b0;
    if0.s_axis_req_tvalid = 1'b1;
    #1;
    check("stall_tready", if0.s_axis_req_tready, 0);
    for (int i = 0; i < 5; i++) begin
      step();
      check("stall_hold_valid", if0.m_axis_req_valid, 8'h10);
      check("stall_hold_data", if0.m_axis_req_data[4], 64'hF1);
      check("stall_hold_tready", if0.s_axis_req_tready, 0);
    end
    if0.m_axis_req_ready[4] = 1'b1;
    #1;
    check("release_tready", if0.s_axis_req_tready, 1);
    step();
    check("stall_b2_data", if0.m_axis_req_data[4], 64'hF2);
    send0(64'hF3, mk_user(1'b0, 3'd7, 32'h0, 96'h0), 1'b1);
    check("stall_b3_data", if0.m_axis_req_data[4], 64'hF3);
    check("stall_b3_last", if0.m_axis_req_last[4], 1);
    step();
    check("stall_drain", if0.m_axis_req_valid, 0);

    // Asynchronous reset mid-packet
    send0(64'h61, mk_user(1'b0, 3'd0, 32'h4010, 96'h0), 1'b0);
    check("prerst_valid", if0.m_axis_req_valid, 8'h10);
    #2;
    rst_n = 1'b0;
    #1;
    check("asyncrst_valid", if0.m_axis_req_valid, 0);
    check("asyncrst_tready", if0.s_axis_req_tready, 0);
    check("asyncrst_miss", miss_cnt0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    send0(64'h62, mk_user(1'b0, 3'd0, 32'h4020, 96'h0), 1'b1);
    check("postrst_valid", if0.m_axis_req_valid, 8'h01);
    check("postrst_data", if0.m_axis_req_data[0], 64'h62);
    check("postrst_miss", miss_cnt0, 1);

    // DROP_MISS=1 instance: 3-beat packet to an unmapped address
    check("drop_b1_tready", if1.s_axis_req_tready, 1);
    send1(64'h71, mk_user(1'b1, 3'd0, 32'h9000, 96'h0), 1'b0);
    check("drop_b1_valid", if1.m_axis_req_valid, 0);
    check("drop_b1_pulse", drop_pulse1, 0);
    check("drop_b2_tready", if1.s_axis_req_tready, 1);
    send1(64'h72, mk_user(1'b1, 3'd0, 32'h9000, 96'h0), 1'b0);
    check("drop_b2_valid", if1.m_axis_req_valid, 0);
    check("drop_b3_tready", if1.s_axis_req_tready, 1);
    send1(64'h73, mk_user(1'b1, 3'd0, 32'h9000, 96'h0), 1'b1);
    check("drop_b3_valid", if1.m_axis_req_valid, 0);
    check("drop_b3_pulse", drop_pulse1, 1);
    check("drop_miss", miss_cnt1, 1);
    step();
    check("drop_pulse_end", drop_pulse1, 0);
    wr_win(3'd0, 32'h0, 32'h100, 8'h01, 1'b1);
    send1(64'h74, mk_user(1'b0, 3'd0, 32'h10, 96'h0), 1'b1);
    check("drop_recover_valid", if1.m_axis_req_valid, 8'h01);
    check("drop_recover_data", if1.m_axis_req_data[0], 64'h74);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pio_req_router.md
PIO_REQ_ROUTER -- requirements
Module: pio_req_router

Interface
REQ-001 Parameter CHANNEL_NUM, default 8, sets the number of output request channels (2..16).
REQ-002 Parameter DATA_W, default `PIO_DATA_W, sets the data beat width.
REQ-003 Parameter ADDR_W, default 32, sets the address bits compared against windows.
REQ-004 Parameter DEF_CHNL, default 0, names the channel used on a window miss when DROP_MISS=0.
REQ-005 Parameter DROP_MISS, default 0; when 1, miss packets are consumed and discarded.
REQ-006 clk  input  1  sole clock.
REQ-007 rst_n  input  1  reset, asynchronous, active-low.
REQ-008 s_axis_req_tdata/tuser/tlast/tvalid  input  DATA_W/`PIO_USER_W/1/1  request stream; tuser fields: is_wr[139], bar_id[138:136], addr[127:96], cc_head[95:0].
REQ-009 s_axis_req_tready  output  1  upstream ready.
REQ-010 m_axis_req_data/head/last/valid  output  CHANNEL_NUM x (DATA_W/`PIO_HEAD_W/1/1)  per-channel request streams; head = {is_wr, bar_id, addr, cc_head}.
REQ-011 m_axis_req_ready  input  CHANNEL_NUM  per-channel ready.
REQ-012 cfg_wr_en  input  1  window-table write strobe.
REQ-013 cfg_idx  input  CHNL_W  window index written (CHNL_W = clog2(CHANNEL_NUM)).
REQ-014 cfg_base/cfg_len  input  ADDR_W each  window base and length.
REQ-015 cfg_bar_mask  input  8  BARs a window responds to (bit n = BAR n).
REQ-016 cfg_en  input  1  window enable.
REQ-017 miss_cnt  output  16  count of head beats that hit no window.
REQ-018 drop_pulse  output  1  one-cycle pulse on tlast of a dropped packet.

Function
REQ-019 The block SHALL hold CHANNEL_NUM windows; window i maps to channel i.
REQ-020 A head hits window i when en_i, bar_mask_i[bar_id] = 1 and base_i <= addr < base_i + len_i, with the sum computed in ADDR_W+1 bits (no wrap).
REQ-021 Among multiple hits, the lowest index SHALL win; len_i = 0 SHALL never hit.
REQ-022 FSM states: IDLE (awaiting first beat), FWD (packet locked to channel), DROP (discarding).
REQ-023 IDLE: an accepted beat with a hit, or a miss with DROP_MISS=0, latches the channel; the FSM goes to FWD unless tlast is set, in which case it stays in IDLE.
REQ-024 IDLE: an accepted miss beat with DROP_MISS=1 goes to DROP unless tlast is set; the beat is never presented downstream.
REQ-025 FWD/DROP: the channel stays locked; the accepted beat carrying tlast returns the FSM to IDLE.
REQ-026 Head fields SHALL be latched on the first beat and replayed on every beat of the packet.
REQ-027 Output register slice: the accepted beat appears on the selected m_axis one cycle later (latency 1); only the selected channel's valid is asserted.
REQ-028 s_axis_req_tready = !out_valid | m_axis_req_ready[locked_chnl], giving full throughput with no bubble.
REQ-029 In DROP state, and on a first-beat miss with DROP_MISS=1, s_axis_req_tready SHALL be 1 whenever the output slice is empty or draining.
REQ-030 A cfg write SHALL take effect the cycle after cfg_wr_en.
REQ-031 A packet in flight keeps its latched channel across cfg writes.
REQ-032 A cfg write in the same cycle as a first beat: the first beat is routed using the old table.
REQ-033 miss_cnt SHALL saturate at 16'hFFFF and increment once per packet.
REQ-034 Downstream valid, once asserted, SHALL hold with stable data until the matching ready.

Reset
REQ-035 On rst_n low: FSM=IDLE, all m_axis_req_valid=0, s_axis_req_tready=0 during reset, miss_cnt=0, drop_pulse=0, all windows disabled (en=0, base=0, len=0, mask=0).
REQ-036 Reset mid-packet discards the partial packet; after release, the next accepted beat is treated as a first beat.

Structure
REQ-037 Shared package/header: `PIO_DATA_W, `PIO_USER_W, `PIO_HEAD_W, tuser field offsets, FSM state encodings.
REQ-038 Sub-module pio_win_match: combinational compare of one head against the window table, returning hit and index.

Verification
REQ-039 Window 2 = {base 0x1000, len 0x100, mask BAR0, en}; 1-beat write to addr 0x10F0 on BAR0 -> channel 2 valid next cycle, head addr 0x10F0.
REQ-040 4-beat packet to window 2; write window 2 base 0x8000 after beat 1 -> all 4 beats reach channel 2; the next packet to 0x10F0 misses.
REQ-041 DROP_MISS=1; 3-beat packet to an unmapped address -> no m_axis valid, tready=1 for 3 cycles, drop_pulse on beat 3, miss_cnt=1.
REQ-042 DROP_MISS=0, DEF_CHNL=0; miss -> channel 0 receives the packet, miss_cnt increments.
REQ-043 Overlapping windows 1 and 3 both hit -> channel 1 selected; window with base 0xFFFFFF00, len 0x200 -> addr 0xFFFFFFF0 hits, no wrap to 0x0.
REQ-044 Channel 4 ready held low 5 cycles mid-packet -> tready low, data stable, no beat lost; async reset asserted mid-packet -> all valids 0 immediately.
